pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Detects load-use hazards against the decode stage's register-read requests and sequences multi-cycle EX operations with a down-counter. Handles flush requests and emits a per-stage stall vector plus a flush strobe to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Holds a saturating stall-cycle performance counter.

Parameters:
MC_CNT_W, 6, width of the multi-cycle latency field and the internal down-counter
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock, rising-edge
rst  in  1  asynchronous, active-low reset (rst==0 resets)
id_reg1_read_i  in  1  decode reads operand port 1
id_reg1_addr_i  in  5  decode operand 1 register address
id_reg2_read_i  in  1  decode reads operand port 2
id_reg2_addr_i  in  5  decode operand 2 register address
ex_is_load_i  in  1  instruction in EX is a load
ex_wd_i  in  5  EX destination register
ex_mc_start_i  in  1  EX issues a multi-cycle op this cycle
ex_mc_cycles_i  in  MC_CNT_W  extra cycles the op needs (N)
flush_i  in  1  branch/exception flush request
clr_cnt_i  in  1  synchronous clear of the performance counter
stall_o  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold stage
flush_o  out  1  kill all in-flight pipeline registers
mc_busy_o  out  1  multi-cycle op in progress
mc_done_o  out  1  one-cycle pulse on the final busy cycle
stall_cycles_o  out  PERF_W  count of cycles with stall_o[0]==1

Behaviour:
- States: IDLE, MC_BUSY. Registered state, counter cnt[MC_CNT_W-1:0], perf counter. stall_o/flush_o/mc_done_o are combinational from state, cnt and inputs.
- Reset (rst==0, async): state=IDLE, cnt=0, stall_cycles_o=0. Outputs stall_o=6'b000000, flush_o=0, mc_busy_o=0, mc_done_o=0. Reset mid-op aborts immediately, with no done pulse.
- Load-use hazard: lu = ex_is_load_i && ex_wd_i!=0 && ((id_reg1_read_i && id_reg1_addr_i==ex_wd_i) || (id_reg2_read_i && id_reg2_addr_i==ex_wd_i)).
- Priority, highest first: flush_i > MC (start or busy) > load-use > none.
- flush_i=1: stall_o=0, flush_o=1, next state IDLE, cnt<=0. A pending MC op is aborted with no mc_done_o. Flush takes effect in the same cycle as any simultaneous start.
- IDLE, ex_mc_start_i=1, N=ex_mc_cycles_i>0: stall_o=6'b001111 this cycle; cnt<=N; next state MC_BUSY.
- IDLE, ex_mc_start_i=1, N=0: treated as single-cycle, no stall, stays IDLE.
- MC_BUSY: stall_o=6'b001111, mc_busy_o=1. cnt decrements each cycle.
  - When cnt==1: mc_done_o=1 and next state is IDLE.
  - Total stall = N+1 cycles including the start cycle; EX result is released in the cycle after mc_done_o.
- ex_mc_start_i is ignored while in MC_BUSY. lu is ignored in MC_BUSY; the 001111 vector already holds ID.
- IDLE, lu=1, no MC start: stall_o=6'b000111 for that cycle (PC/IF/ID held, bubble into EX). This repeats naturally while lu persists.
- ex_wd_i==0 never causes a hazard, because $zero is never written.
- Perf counter: increments when stall_o[0]==1, saturates at all-ones.
  - clr_cnt_i clears it to 0 and wins over a simultaneous increment.
  - A flush cycle is not counted.

Decomposition:
- defines.v gains:
  - `StallBus 5:0
  - `StallNone 6'b000000
  - `StallLoadUse 6'b000111
  - `StallMulti 6'b001111
  - `CtrlIdle, `CtrlMcBusy state codes
  - `RstnEnable 1'b0
- One sub-module, pipe_ctrl_perf_cnt: a parameterised saturating counter with enable and synchronous clear.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release rst; idle inputs -> stall_o=000000, stall_cycles_o=0.
- Load-use: ex_is_load_i=1, ex_wd_i=5, id_reg2_read_i=1, id_reg2_addr_i=5 for 1 cycle -> stall_o=000111 that cycle, stall_cycles_o=1. Same with ex_wd_i=0 -> stall_o=000000.
- Multi-cycle: ex_mc_start_i=1, N=3 -> stall_o=001111 for 4 cycles; mc_busy_o high for cycles 2-4; mc_done_o high in cycle 4 only; then IDLE and stall_cycles_o=4. N=0 -> no stall.
- Flush mid-op: N=10, flush_i at busy cycle 3 -> flush_o=1, stall_o=0 that cycle, next cycle IDLE, no mc_done_o. Simultaneous flush_i and ex_mc_start_i -> flush only, remains IDLE.
- Priority: MC busy while load-use condition true -> stall_o=001111, not 000111. load-use and ex_mc_start_i in the same IDLE cycle -> 001111.
- Counter: PERF_W=4, 20 consecutive stall cycles -> stall_cycles_o=15 (saturated). clr_cnt_i during a stall -> 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall vectors, sequencer state codes and the load-use hazard rule.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE     = 6'b000000;
    localparam stall_bus_t STALL_LOAD_USE = 6'b000111;
    localparam stall_bus_t STALL_MULTI    = 6'b001111;

    localparam logic [0:0] CTRL_IDLE    = 1'b0;
    localparam logic [0:0] CTRL_MC_BUSY = 1'b1;

    localparam logic RSTN_ENABLE = 1'b0;

    // Register $zero is never written, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hazard(
        input logic       ex_is_load,
        input logic [4:0] ex_wd,
        input logic       reg1_read,
        input logic [4:0] reg1_addr,
        input logic       reg2_read,
        input logic [4:0] reg2_addr
    );
        return ex_is_load && (ex_wd != 5'd0) &&
               ((reg1_read && (reg1_addr == ex_wd)) ||
                (reg2_read && (reg2_addr == ex_wd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline stages and the pipeline sequencer.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
);
    logic                id_reg1_read_i;
    logic [4:0]          id_reg1_addr_i;
    logic                id_reg2_read_i;
    logic [4:0]          id_reg2_addr_i;
    logic                ex_is_load_i;
    logic [4:0]          ex_wd_i;
    logic                ex_mc_start_i;
    logic [MC_CNT_W-1:0] ex_mc_cycles_i;
    logic                flush_i;
    logic                clr_cnt_i;
    stall_bus_t          stall_o;
    logic                flush_o;
    logic                mc_busy_o;
    logic                mc_done_o;
    logic [PERF_W-1:0]   stall_cycles_o;

    modport master (
        output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        output ex_is_load_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
        output flush_i, clr_cnt_i,
        input  stall_o, flush_o, mc_busy_o, mc_done_o, stall_cycles_o
    );

    modport slave (
        input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        input  ex_is_load_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
        input  flush_i, clr_cnt_i,
        output stall_o, flush_o, mc_busy_o, mc_done_o, stall_cycles_o
    );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating up-counter with enable; a synchronous clear overrides counting.
module pipe_ctrl_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, multi-cycle EX sequencing, flush strobe
// and a saturating count of cycles in which the PC was held.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [MC_CNT_W-1:0] cnt;
    logic [MC_CNT_W-1:0] cnt_nxt;
    stall_bus_t          stall;
    logic                flush;
    logic                mc_done;
    logic                lu;
    logic [PERF_W-1:0]   perf_count;

    assign lu = load_use_hazard(bus.ex_is_load_i, bus.ex_wd_i,
                                bus.id_reg1_read_i, bus.id_reg1_addr_i,
                                bus.id_reg2_read_i, bus.id_reg2_addr_i);

    // Priority: flush, then an active or starting multi-cycle op, then load-use.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = STALL_NONE;
        flush     = 1'b0;
        mc_done   = 1'b0;
        if (rst != RSTN_ENABLE) begin
            if (bus.flush_i) begin
                flush     = 1'b1;
                state_nxt = CTRL_IDLE;
                cnt_nxt   = '0;
            end else if (state == CTRL_MC_BUSY) begin
                stall   = STALL_MULTI;
                cnt_nxt = cnt - 1'b1;
                if (cnt == {{(MC_CNT_W-1){1'b0}}, 1'b1}) begin
                    mc_done   = 1'b1;
                    state_nxt = CTRL_IDLE;
                end
            end else if (bus.ex_mc_start_i && (bus.ex_mc_cycles_i != '0)) begin
                stall     = STALL_MULTI;
                cnt_nxt   = bus.ex_mc_cycles_i;
                state_nxt = CTRL_MC_BUSY;
            end else if (lu) begin
                stall = STALL_LOAD_USE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            state <= CTRL_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A flush forces the stall vector to zero, so flush cycles are never counted.
    pipe_ctrl_perf_cnt #(
        .W (PERF_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall[0]),
        .clr   (bus.clr_cnt_i),
        .count (perf_count)
    );

    assign bus.stall_o        = stall;
    assign bus.flush_o        = flush;
    assign bus.mc_busy_o      = (state == CTRL_MC_BUSY);
    assign bus.mc_done_o      = mc_done;
    assign bus.stall_cycles_o = perf_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, corner sequences and a random run.
module tb_pipe_ctrl;

    localparam int PERF_MAX = 15;

    typedef struct packed {
        logic       r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2;
        logic       ld;
        logic [4:0] wd;
        logic       st;
        logic [5:0] n;
        logic       fl;
        logic       clr;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
        logic [3:0] perf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if #(.MC_CNT_W(6), .PERF_W(4)) bus ();

    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(logic ld, logic [4:0] wd, logic r1, logic [4:0] a1,
                                  logic r2, logic [4:0] a2, logic st, logic [5:0] n,
                                  logic fl, logic clr);
        in_t i;
        i.ld = ld; i.wd = wd; i.r1 = r1; i.a1 = a1; i.r2 = r2; i.a2 = a2;
        i.st = st; i.n = n; i.fl = fl; i.clr = clr;
        return i;
    endfunction

    function automatic vec_t mk_vec(in_t i, logic [5:0] stall, logic flush, logic busy,
                                    logic done, logic [3:0] perf);
        vec_t v;
        v.in = i; v.stall = stall; v.flush = flush; v.busy = busy; v.done = done; v.perf = perf;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.r1  = 1'($urandom_range(0, 1));
        i.a1  = 5'($urandom_range(0, 3));
        i.r2  = 1'($urandom_range(0, 1));
        i.a2  = 5'($urandom_range(0, 3));
        i.ld  = 1'($urandom_range(0, 1));
        i.wd  = 5'($urandom_range(0, 3));
        i.st  = ($urandom_range(0, 7) == 0);
        i.n   = 6'($urandom_range(0, 7));
        i.fl  = ($urandom_range(0, 19) == 0);
        i.clr = ($urandom_range(0, 29) == 0);
        return i;
    endfunction

    task automatic drive(input in_t i);
        bus.id_reg1_read_i = i.r1;
        bus.id_reg1_addr_i = i.a1;
        bus.id_reg2_read_i = i.r2;
        bus.id_reg2_addr_i = i.a2;
        bus.ex_is_load_i   = i.ld;
        bus.ex_wd_i        = i.wd;
        bus.ex_mc_start_i  = i.st;
        bus.ex_mc_cycles_i = i.n;
        bus.flush_i        = i.fl;
        bus.clr_cnt_i      = i.clr;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check_output({tag, ".stall"}, 32'(bus.stall_o), 32'(v.stall));
        check_output({tag, ".flush"}, 32'(bus.flush_o), 32'(v.flush));
        check_output({tag, ".busy"},  32'(bus.mc_busy_o), 32'(v.busy));
        check_output({tag, ".done"},  32'(bus.mc_done_o), 32'(v.done));
        check_output({tag, ".perf"},  32'(bus.stall_cycles_o), 32'(v.perf));
    endtask

    // Drive one cycle of inputs just after a rising edge, compare at the falling edge.
    task automatic apply_stimulus(input string tag, input vec_t v);
        drive(v.in);
        @(negedge clk);
        check_all(tag, v);
        @(posedge clk);
        #1;
    endtask

    // Reference model: a multi-cycle op occupies an absolute window of cycle numbers.
    int cyc;
    int mc_first;
    int mc_last;
    int perf_m;

    function automatic void model_reset();
        cyc = 0; mc_first = 0; mc_last = -1; perf_m = 0;
    endfunction

    function automatic vec_t model_step(input in_t i);
        vec_t v;
        logic lu;
        logic busy_now;
        lu = i.ld && (i.wd != 0) && ((i.r1 && i.a1 == i.wd) || (i.r2 && i.a2 == i.wd));
        busy_now = (cyc >= mc_first) && (cyc <= mc_last);
        v = mk_vec(i, 6'b000000, 1'b0, busy_now, 1'b0, 4'(perf_m));
        if (i.fl) begin
            v.flush = 1'b1;
            mc_last = -1;
        end else if (busy_now) begin
            v.stall = 6'b001111;
            v.done  = (cyc == mc_last);
        end else if (i.st && i.n != 0) begin
            v.stall  = 6'b001111;
            mc_first = cyc + 1;
            mc_last  = cyc + int'(i.n);
        end else if (lu) begin
            v.stall = 6'b000111;
        end
        if (i.clr)             perf_m = 0;
        else if (v.stall[0])   perf_m = (perf_m < PERF_MAX) ? perf_m + 1 : PERF_MAX;
        cyc++;
        return v;
    endfunction

    vec_t tbl[20];
    in_t  idle;
    in_t  lu5;

    initial begin
        n_vec = 0;
        n_err = 0;
        idle  = '0;
        lu5   = mk_in(1, 5, 0, 0, 1, 5, 0, 0, 0, 0);

        tbl[0]  = mk_vec(idle,                                  6'b000000, 0, 0, 0, 0);
        tbl[1]  = mk_vec(lu5,                                   6'b000111, 0, 0, 0, 0);
        tbl[2]  = mk_vec(idle,                                  6'b000000, 0, 0, 0, 1);
        tbl[3]  = mk_vec(mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0),   6'b000000, 0, 0, 0, 1);
        tbl[4]  = mk_vec(mk_in(1, 7, 1, 7, 0, 0, 0, 0, 0, 0),   6'b000111, 0, 0, 0, 1);
        tbl[5]  = mk_vec(mk_in(1, 7, 0, 7, 0, 7, 0, 0, 0, 0),   6'b000000, 0, 0, 0, 2);
        tbl[6]  = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 3, 0, 0),   6'b001111, 0, 0, 0, 2);
        tbl[7]  = mk_vec(idle,                                  6'b001111, 0, 1, 0, 3);
        tbl[8]  = mk_vec(mk_in(1, 5, 0, 0, 1, 5, 1, 5, 0, 0),   6'b001111, 0, 1, 0, 4);
        tbl[9]  = mk_vec(idle,                                  6'b001111, 0, 1, 1, 5);
        tbl[10] = mk_vec(idle,                                  6'b000000, 0, 0, 0, 6);
        tbl[11] = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),   6'b000000, 0, 0, 0, 6);
        tbl[12] = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 4, 1, 0),   6'b000000, 1, 0, 0, 6);
        tbl[13] = mk_vec(idle,                                  6'b000000, 0, 0, 0, 6);
        tbl[14] = mk_vec(mk_in(1, 5, 0, 0, 1, 5, 1, 2, 0, 0),   6'b001111, 0, 0, 0, 6);
        tbl[15] = mk_vec(idle,                                  6'b001111, 0, 1, 0, 7);
        tbl[16] = mk_vec(idle,                                  6'b001111, 0, 1, 1, 8);
        tbl[17] = mk_vec(idle,                                  6'b000000, 0, 0, 0, 9);
        tbl[18] = mk_vec(mk_in(1, 5, 0, 0, 1, 5, 0, 0, 0, 1),   6'b000111, 0, 0, 0, 9);
        tbl[19] = mk_vec(idle,                                  6'b000000, 0, 0, 0, 0);

        // Reset held with random inputs: every output must stay quiet.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(rand_in());
            @(negedge clk);
            check_all($sformatf("rst_hold[%0d]", k), mk_vec(idle, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        for (int k = 0; k < 20; k++) apply_stimulus($sformatf("tbl[%0d]", k), tbl[k]);

        // Flush three cycles into a ten-cycle op: no done pulse, back to idle.
        apply_stimulus("fl_start", mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 10, 0, 0), 6'b001111, 0, 0, 0, 0));
        apply_stimulus("fl_busy1", mk_vec(idle, 6'b001111, 0, 1, 0, 1));
        apply_stimulus("fl_busy2", mk_vec(idle, 6'b001111, 0, 1, 0, 2));
        apply_stimulus("fl_kill",  mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 6'b000000, 1, 1, 0, 3));
        for (int k = 0; k < 10; k++)
            apply_stimulus($sformatf("fl_after[%0d]", k), mk_vec(idle, 6'b000000, 0, 0, 0, 3));

        // Twenty load-use cycles saturate the 4-bit counter; clear then wins over a stall.
        for (int k = 0; k < 20; k++)
            apply_stimulus($sformatf("sat[%0d]", k),
                           mk_vec(lu5, 6'b000111, 0, 0, 0, 4'((3 + k > PERF_MAX) ? PERF_MAX : 3 + k)));
        apply_stimulus("sat_clr", mk_vec(mk_in(1, 5, 0, 0, 1, 5, 0, 0, 0, 1), 6'b000111, 0, 0, 0, 15));
        apply_stimulus("sat_zero", mk_vec(idle, 6'b000000, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a multi-cycle op.
        apply_stimulus("ar_start", mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 5, 0, 0), 6'b001111, 0, 0, 0, 0));
        apply_stimulus("ar_busy",  mk_vec(idle, 6'b001111, 0, 1, 0, 1));
        drive(lu5);
        rst = 1'b0;
        #1;
        check_all("ar_in_reset", mk_vec(idle, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++)
            apply_stimulus($sformatf("ar_after[%0d]", k), mk_vec(idle, 6'b000000, 0, 0, 0, 0));

        // Random run against the reference model from a fresh reset.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 600; k++) begin
            in_t  ri;
            vec_t ev;
            ri = rand_in();
            ev = model_step(ri);
            apply_stimulus($sformatf("rnd[%0d]", k), ev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
